lfsr_serial_checker: RTL and testbench

//  Downstream stage of the LFSR serial unloader: captures the LSB-first serial
//  bit stream, rebuilds LFSR_WD-bit words and flags each word against an

---
 rtl/lfsr_serial_checker_if.sv | 37 +++
 rtl/lfsr_serial_checker.sv | 129 ++++++++++++
 tb/tb_lfsr_serial_checker.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_serial_checker_if.sv
// Bundle between the LFSR serial unloader pin and the checker: serial input
// side, reference/compare controls and the word/error status returned.
interface lfsr_serial_checker_if #(
  parameter int LFSR_WD = 8,
  parameter int CNT_WD  = 8
);
  // Handshake: there is no back-pressure. Serial_In is consumed on every rising
  // edge where In_Valid=1 and Sync=0. Expected/Expect_En only matter on the edge
  // that samples the last bit of a word. Word_Valid is a one-cycle pulse.
  logic               Serial_In;
  logic               In_Valid;
  logic               Sync;
  logic [LFSR_WD-1:0] Expected;
  logic               Expect_En;
  logic               Clr_Err;

  logic [LFSR_WD-1:0] Data_Out;
  logic               Word_Valid;
  logic               Match;
  logic               Err_Flag;
  logic [CNT_WD-1:0]  Err_Count;
  logic [CNT_WD-1:0]  Word_Count;
  logic               Busy;
  logic [1:0]         State_Dbg;

  modport master (
    output Serial_In, In_Valid, Sync, Expected, Expect_En, Clr_Err,
    input  Data_Out, Word_Valid, Match, Err_Flag, Err_Count, Word_Count, Busy,
           State_Dbg
  );

  modport slave (
    input  Serial_In, In_Valid, Sync, Expected, Expect_En, Clr_Err,
    output Data_Out, Word_Valid, Match, Err_Flag, Err_Count, Word_Count, Busy,
           State_Dbg
  );
endinterface

// File: rtl/lfsr_serial_checker.sv
// Rebuilds LSB-first serial words from the LFSR unloader, compares each word
// with a reference and keeps sticky/saturating error status for the run.
module lfsr_serial_checker #(
  parameter int LFSR_WD = 8,
  parameter int CNT_WD  = 8
) (
  input logic                   CLK,
  input logic                   RST,
  lfsr_serial_checker_if.slave  bus
);

  localparam int                BC_WD    = $clog2(LFSR_WD);
  localparam logic [BC_WD-1:0]  LAST_BIT = BC_WD'(LFSR_WD - 1);
  localparam logic [CNT_WD-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;

  state_t             state_q, state_d;
  logic [BC_WD-1:0]   cnt_q, cnt_d;
  logic [LFSR_WD-1:0] sreg_q, sreg_d;
  logic               word_done;
  logic               word_eq;
  logic               mismatch;

  logic [LFSR_WD-1:0] data_q;
  logic               wv_q;
  logic               match_q;
  logic               busy_q;
  logic               err_flag_q, err_flag_d;
  logic [CNT_WD-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_WD-1:0]  word_cnt_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

  // Sync outranks In_Valid: the bit on a Sync edge is dropped with the partial word.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    word_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.Sync && bus.In_Valid) begin
          sreg_d  = {bus.Serial_In, sreg_q[LFSR_WD-1:1]};
          cnt_d   = BC_WD'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.Sync) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (bus.In_Valid) begin
          sreg_d = {bus.Serial_In, sreg_q[LFSR_WD-1:1]};
          if (cnt_q == LAST_BIT) begin
            word_done = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Clear is applied first so a coincident mismatch still counts as one error.
  always_comb begin
    word_eq    = (sreg_d == bus.Expected);
    mismatch   = word_done && bus.Expect_En && !word_eq;
    err_flag_d = bus.Clr_Err ? 1'b0 : err_flag_q;
    err_cnt_d  = bus.Clr_Err ? '0   : err_cnt_q;
    if (mismatch) begin
      err_flag_d = 1'b1;
      if (err_cnt_d != CNT_MAX) begin
        err_cnt_d = err_cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q     <= '0;
      wv_q       <= 1'b0;
      match_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      wv_q       <= word_done;
      busy_q     <= (cnt_d != '0);
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
      if (word_done) begin
        data_q     <= sreg_d;
        match_q    <= bus.Expect_En && word_eq;
        word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  assign bus.Data_Out   = data_q;
  assign bus.Word_Valid = wv_q;
  assign bus.Match      = match_q;
  assign bus.Err_Flag   = err_flag_q;
  assign bus.Err_Count  = err_cnt_q;
  assign bus.Word_Count = word_cnt_q;
  assign bus.Busy       = busy_q;
  assign bus.State_Dbg  = state_q;

endmodule

// File: tb/tb_lfsr_serial_checker.sv
// Bench for lfsr_serial_checker: two instances (8-bit and 2-bit counters) share
// one stimulus stream; a queue-based word model is compared every cycle.
module tb_lfsr_serial_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       serial_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       sync = 1'b0;
  logic [7:0] expected = 8'h00;
  logic       expect_en = 1'b0;
  logic       clr_err = 1'b0;
  logic       cmp_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lfsr_serial_checker_if #(.LFSR_WD(8), .CNT_WD(8)) ifa ();
  lfsr_serial_checker_if #(.LFSR_WD(8), .CNT_WD(2)) ifb ();

  assign ifa.Serial_In = serial_in;
  assign ifa.In_Valid  = in_valid;
  assign ifa.Sync      = sync;
  assign ifa.Expected  = expected;
  assign ifa.Expect_En = expect_en;
  assign ifa.Clr_Err   = clr_err;
  assign ifb.Serial_In = serial_in;
  assign ifb.In_Valid  = in_valid;
  assign ifb.Sync      = sync;
  assign ifb.Expected  = expected;
  assign ifb.Expect_En = expect_en;
  assign ifb.Clr_Err   = clr_err;

  lfsr_serial_checker #(.LFSR_WD(8), .CNT_WD(8)) dut_a (
    .CLK (clk),
    .RST (rst_n),
    .bus (ifa.slave)
  );

  lfsr_serial_checker #(.LFSR_WD(8), .CNT_WD(2)) dut_b (
    .CLK (clk),
    .RST (rst_n),
    .bus (ifb.slave)
  );

  // ---------------- model: collect bits in a queue, evaluate whole words
  logic       bit_q[$];
  logic [7:0] m_data  = 8'h00;
  logic       m_wv    = 1'b0;
  logic       m_match = 1'b0;
  logic       m_flag  = 1'b0;
  int         m_err_a = 0;
  int         m_err_b = 0;
  int         m_words = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q.delete();
      m_data = 8'h00; m_wv = 1'b0; m_match = 1'b0; m_flag = 1'b0;
      m_err_a = 0; m_err_b = 0; m_words = 0;
    end else begin
      logic [7:0] w;
      m_wv = 1'b0;
      if (clr_err) begin
        m_flag = 1'b0; m_err_a = 0; m_err_b = 0;
      end
      if (sync) begin
        bit_q.delete();
      end else if (in_valid) begin
        bit_q.push_back(serial_in);
        if (bit_q.size() == 8) begin
          for (int i = 0; i < 8; i++) w[i] = bit_q[i];
          bit_q.delete();
          m_data = w;
          m_wv = 1'b1;
          m_words++;
          if (expect_en) begin
            m_match = (w == expected);
            if (!m_match) begin
              m_flag = 1'b1;
              if (m_err_a < 255) m_err_a++;
              if (m_err_b < 3) m_err_b++;
            end
          end else begin
            m_match = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- per-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      logic busy_m;
      busy_m = (bit_q.size() != 0);
      chk("a.data",  32'(ifa.Data_Out),   32'(m_data));
      chk("a.wv",    32'(ifa.Word_Valid), 32'(m_wv));
      chk("a.match", 32'(ifa.Match),      32'(m_match));
      chk("a.flag",  32'(ifa.Err_Flag),   32'(m_flag));
      chk("a.errc",  32'(ifa.Err_Count),  32'(m_err_a));
      chk("a.wcnt",  32'(ifa.Word_Count), 32'(m_words % 256));
      chk("a.busy",  32'(ifa.Busy),       32'(busy_m));
      chk("a.state", 32'(ifa.State_Dbg),  busy_m ? 32'd1 : 32'd0);
      chk("b.data",  32'(ifb.Data_Out),   32'(m_data));
      chk("b.wv",    32'(ifb.Word_Valid), 32'(m_wv));
      chk("b.match", 32'(ifb.Match),      32'(m_match));
      chk("b.flag",  32'(ifb.Err_Flag),   32'(m_flag));
      chk("b.errc",  32'(ifb.Err_Count),  32'(m_err_b));
      chk("b.wcnt",  32'(ifb.Word_Count), 32'(m_words % 4));
      chk("b.busy",  32'(ifb.Busy),       32'(busy_m));
    end
  end

  // ---------------- driver tasks (inputs change 1 time unit after negedge)
  task automatic send_bit(input logic b, input logic v, input logic s);
    @(negedge clk);
    #1;
    serial_in = b;
    in_valid  = v;
    sync      = s;
    clr_err   = 1'b0;
  endtask

  task automatic tick();
    send_bit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick_clr();
    send_bit(1'b0, 1'b0, 1'b0);
    clr_err = 1'b1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic [7:0] exp,
                           input logic en, input logic clr_last);
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], 1'b1, 1'b0);
      expected  = exp;
      expect_en = en;
      clr_err   = clr_last && (i == 7);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    serial_in = 1'b0; in_valid = 1'b0; sync = 1'b0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed scenarios with literal expectations
  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    #1 rst_n = 1'b1;

    // reset asserted mid-word, then 1,0,1,0,0,1,0,1 -> 8'hA5
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst.a.busy",  32'(ifa.Busy),       32'd0);
    chk("rst.a.data",  32'(ifa.Data_Out),   32'd0);
    chk("rst.a.wcnt",  32'(ifa.Word_Count), 32'd0);
    chk("rst.b.busy",  32'(ifb.Busy),       32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    send_word(8'hA5, 8'hA5, 1'b1, 1'b0);
    tick();
    chk("t2.data",  32'(ifa.Data_Out),   32'hA5);
    chk("t2.match", 32'(ifa.Match),      32'd1);
    chk("t2.wv",    32'(ifa.Word_Valid), 32'd1);
    chk("t2.wcnt",  32'(ifa.Word_Count), 32'd1);
    tick();
    chk("t2.wv_off", 32'(ifa.Word_Valid), 32'd0);
    chk("t2.hold",   32'(ifa.Data_Out),   32'hA5);

    // back-to-back words, second mismatches
    do_reset();
    send_word(8'h3C, 8'h3C, 1'b1, 1'b0);
    send_word(8'hC3, 8'h3C, 1'b1, 1'b0);
    tick();
    chk("t3.data",  32'(ifa.Data_Out),   32'hC3);
    chk("t3.match", 32'(ifa.Match),      32'd0);
    chk("t3.flag",  32'(ifa.Err_Flag),   32'd1);
    chk("t3.errc",  32'(ifa.Err_Count),  32'd1);
    chk("t3.wcnt",  32'(ifa.Word_Count), 32'd2);

    // partial word dropped by Sync (with In_Valid), then 8'h5A
    do_reset();
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b1);
    tick();
    chk("t4.busy_sync", 32'(ifa.Busy), 32'd0);
    send_word(8'h5A, 8'h5A, 1'b1, 1'b0);
    tick();
    chk("t4.data",  32'(ifa.Data_Out),   32'h5A);
    chk("t4.wcnt",  32'(ifa.Word_Count), 32'd1);
    chk("t4.match", 32'(ifa.Match),      32'd1);

    // saturation in the 2-bit counter, clear coincident with a mismatch
    do_reset();
    for (int k = 0; k < 5; k++) send_word(8'h11, 8'h22, 1'b1, 1'b0);
    tick();
    chk("t5.b.errc", 32'(ifb.Err_Count), 32'd3);
    chk("t5.a.errc", 32'(ifa.Err_Count), 32'd5);
    chk("t5.b.wcnt", 32'(ifb.Word_Count), 32'd1);
    send_word(8'h11, 8'h22, 1'b1, 1'b1);
    tick();
    chk("t5.clr_mm.b.errc", 32'(ifb.Err_Count), 32'd1);
    chk("t5.clr_mm.a.errc", 32'(ifa.Err_Count), 32'd1);
    chk("t5.clr_mm.flag",   32'(ifb.Err_Flag),  32'd1);
    send_word(8'h11, 8'h11, 1'b1, 1'b0);
    tick_clr();
    tick();
    chk("t5.clr.flag",  32'(ifa.Err_Flag),  32'd0);
    chk("t5.clr.errc",  32'(ifb.Err_Count), 32'd0);
    chk("t5.clr.match", 32'(ifa.Match),     32'd1);

    // gappy input, compare disabled
    do_reset();
    begin
      logic [7:0] w;
      w = 8'h81;
      for (int i = 0; i < 8; i++) begin
        send_bit(w[i], 1'b1, 1'b0);
        expected  = 8'h00;
        expect_en = 1'b0;
        if (i < 7) begin
          tick();
          chk("t6.busy_gap", 32'(ifa.Busy), 32'd1);
        end
      end
    end
    tick();
    chk("t6.data",  32'(ifa.Data_Out),   32'h81);
    chk("t6.wv",    32'(ifa.Word_Valid), 32'd1);
    chk("t6.match", 32'(ifa.Match),      32'd0);
    chk("t6.errc",  32'(ifa.Err_Count),  32'd0);
    tick();
    chk("t6.wv_off", 32'(ifa.Word_Valid), 32'd0);

    repeat (3) tick();
    @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
